multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Moore-FSM main controller for the multi-cycle MIPS datapath; successor to the single-cycle decoder.
//  Sequences FETCH/DECODE/EXEC/MEM/WB per instruction.
//  Stalls on a memory ready handshake.
//  Drives all datapath enables, muxes and ALUOp; flags illegal opcodes and retires instructions.
// PARAMETERS
//  OPCODE_W  6  opcode field width (values above 6 bits: upper bits must be 0 for a legal op)
//  ALUOP_W   3  ALUOp width, >=3; codes zero-extended
// PORTS
//  clk            in   1         clock, rising edge
//  rst_n          in   1         asynchronous reset, active-low
//  opcode         in   OPCODE_W  IR[31:26], valid from DECODE onward
//  mem_ready      in   1         memory completes access this cycle
//  pc_write       out  1         unconditional PC load
//  branch_eq/ne/gtz out 1 each   conditional PC load qualifiers
//  iord           out  1         0=PC addresses memory, 1=ALUOut
//  mem_read/mem_write out 1 each memory strobes, held until mem_ready
//  ir_write       out  1         latch instruction register
//  mem_to_reg, reg_dst, reg_write, alu_src_a  out 1 each
//  alu_src_b      out  2         00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  alu_op         out  ALUOP_W   000 add, 001 sub(branch), 010 addi, 100 R-type funct
//  pc_source      out  2         00 ALU, 01 ALUOut, 10 jump target
//  illegal_op     out  1         1-cycle pulse on undecodable opcode
//  instr_done     out  1         1-cycle pulse in final state of each instruction
// BEHAVIOUR
//  Reset (async): state=IDLE; every output 0. IDLE->FETCH on first clk after rst_n rises.
//  FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=add.
//    ir_write, pc_write asserted only when mem_ready=1.
//    Stay in FETCH while mem_ready=0; ->DECODE when 1.
//  DECODE: alu_src_a=0, alu_src_b=11, alu_op=add (branch target). Dispatch on opcode:
//    000000 R->EXEC_R; 100011 lw /101011 sw ->MEM_ADDR; 001000 addi->EXEC_I;
//    000100 beq /000101 bne /000111 bgtz ->BRANCH; other ->FETCH with illegal_op=1, instr_done=0.
//  EXEC_R: a=1, b=00, op=100 -> R_WB (reg_dst=1, reg_write=1, instr_done=1) -> FETCH.
//  EXEC_I: a=1, b=10, op=010 -> I_WB (reg_dst=0, reg_write=1, instr_done=1) -> FETCH.
//  MEM_ADDR: a=1, b=10, op=add; lw->MEM_READ, sw->MEM_WRITE.
//  MEM_READ: mem_read=1, iord=1; hold until mem_ready, then ->MEM_WB.
//    MEM_WB: mem_to_reg=1, reg_write=1, instr_done=1.
//  MEM_WRITE: mem_write=1, iord=1; hold until mem_ready; instr_done=1 in the mem_ready cycle; ->FETCH.
//  BRANCH: a=1, b=00, op=001, pc_source=01.
//    Exactly one of branch_eq/ne/gtz per opcode; instr_done=1; ->FETCH.
//  Zero-wait latencies (cycles, FETCH..last): R 4, addi 4, sw 4, lw 5, branch 3, jump 3.
//  Strobes never change while a memory access waits; mem_ready ignored outside FETCH/MEM_READ/MEM_WRITE.
//  rst_n low mid-access: immediate IDLE, strobes drop asynchronously; no partial write committed by control.
//  Outputs decode from state and mem_ready only; opcode is sampled only in DECODE (and MEM_ADDR sw/lw select).
// CONFIGURATION
//  JUMP_EN defined: opcode 000010 ->JUMP state: pc_write=1, pc_source=10, instr_done=1; ->FETCH.
//  JUMP_EN undefined: no JUMP state; 000010 treated as illegal (illegal_op pulse, ->FETCH).
// STRUCTURE
//  Shared package mips_ctrl_pkg: state encodings, opcode constants, ALUOp/alu_src_b/pc_source codes.
//  One sub-module: opcode_class_decoder (combinational opcode -> one-hot class {r,lw,sw,addi,beq,bne,bgtz,j,illegal}).
//  Reused by hazard/debug logic.
// TESTING
//  1. rst_n=0 2 cycles then release -> all outputs 0 in reset; IDLE then FETCH with mem_read=1.
//  2. R-type, mem_ready=1 -> states FETCH,DECODE,EXEC_R,R_WB; reg_write=1 cycle 4; instr_done once.
//  3. lw with mem_ready low 3 cycles in MEM_READ -> mem_read,iord held 4 cycles; MEM_WB reached; total 8 cycles.
//  4. bne (000101) -> branch_ne=1 only, alu_op=001, pc_source=01 in cycle 3; others 0.
//  5. opcode 111111 -> illegal_op pulse in DECODE, next state FETCH, no reg_write/instr_done.
//  6. sw waiting in MEM_WRITE, rst_n dropped -> mem_write 0 same cycle; restart via IDLE.
//     Repeat opcode 000010 with/without JUMP_EN.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states,
// opcode values, opcode classes and the datapath mux/ALUOp codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_R_WB,
    S_EXEC_I,
    S_I_WB,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_BRANCH,
    S_JUMP
  } state_t;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUOp codes, zero-extended to the configured ALUOp width
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_ADDI  = 3'b010;
  localparam logic [2:0] ALU_RTYPE = 3'b100;

  // ALU B-operand select
  localparam logic [1:0] ASB_B      = 2'b00;
  localparam logic [1:0] ASB_FOUR   = 2'b01;
  localparam logic [1:0] ASB_IMM    = 2'b10;
  localparam logic [1:0] ASB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // One-hot opcode class; exactly one bit is set for any opcode
  typedef struct packed {
    logic r;
    logic lw;
    logic sw;
    logic addi;
    logic beq;
    logic bne;
    logic bgtz;
    logic j;
    logic illegal;
  } opclass_t;

endpackage

// File: rtl/opcode_class_decoder.sv
// Combinational opcode -> one-hot class decoder. Shared with hazard and
// debug logic. Jumps decode as legal only when JUMP_EN is defined.
module opcode_class_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output opclass_t            cls_o
);

  logic [5:0] op6;
  logic       upper_zero;

  // Opcodes wider than six bits are legal only with the extra bits clear
  generate
    if (OPCODE_W > 6) begin : g_wide
      assign upper_zero = ~|opcode_i[OPCODE_W-1:6];
      assign op6        = opcode_i[5:0];
    end else begin : g_narrow
      assign upper_zero = 1'b1;
      assign op6        = 6'(opcode_i);
    end
  endgenerate

  // Classify the six-bit primary opcode
  always_comb begin
    cls_o = '0;
    if (!upper_zero) begin
      cls_o.illegal = 1'b1;
    end else begin
      case (op6)
        OP_RTYPE: cls_o.r    = 1'b1;
        OP_LW:    cls_o.lw   = 1'b1;
        OP_SW:    cls_o.sw   = 1'b1;
        OP_ADDI:  cls_o.addi = 1'b1;
        OP_BEQ:   cls_o.beq  = 1'b1;
        OP_BNE:   cls_o.bne  = 1'b1;
        OP_BGTZ:  cls_o.bgtz = 1'b1;
`ifdef JUMP_EN
        OP_J:     cls_o.j       = 1'b1;
`else
        OP_J:     cls_o.illegal = 1'b1;
`endif
        default:  cls_o.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore main controller for the multi-cycle MIPS datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB, stalls on mem_ready.
// Optional feature: define JUMP_EN to add the JUMP state (opcode 000010).
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                branch_eq,
  output logic                branch_ne,
  output logic                branch_gtz,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [1:0]          pc_source,
  output logic                illegal_op,
  output logic                instr_done
);

  state_t     state_q, state_d;
  opclass_t   cls;
  logic       is_sw_q;
  logic [2:0] br_q;     // {gtz, ne, eq}
  logic [2:0] aluop3;

  opcode_class_decoder #(.OPCODE_W(OPCODE_W)) u_dec (
    .opcode_i (opcode),
    .cls_o    (cls)
  );

  assign alu_op = ALUOP_W'(aluop3);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Capture the class bits later states need, so opcode is only read in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_sw_q <= 1'b0;
      br_q    <= '0;
    end else if (state_q == S_DECODE) begin
      is_sw_q <= cls.sw;
      br_q    <= {cls.bgtz, cls.bne, cls.beq};
    end
  end

  // Next state and datapath controls
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;
    branch_gtz = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ASB_B;
    aluop3     = ALU_ADD;
    pc_source  = PCS_ALU;
    illegal_op = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        // PC+4 and IR load commit only in the cycle memory delivers
        mem_read  = 1'b1;
        alu_src_b = ASB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode dispatches
        alu_src_b = ASB_IMM_SH;
        state_d   = S_FETCH;
        if (cls.r)                          state_d = S_EXEC_R;
        else if (cls.lw | cls.sw)           state_d = S_MEM_ADDR;
        else if (cls.addi)                  state_d = S_EXEC_I;
        else if (cls.beq | cls.bne | cls.bgtz) state_d = S_BRANCH;
`ifdef JUMP_EN
        else if (cls.j)                     state_d = S_JUMP;
        illegal_op = cls.illegal;
`else
        // j is never set when jumps are disabled; folding it in keeps the
        // whole class bus consumed
        illegal_op = cls.illegal | cls.j;
`endif
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_B;
        aluop3    = ALU_RTYPE;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_IMM;
        aluop3    = ALU_ADDI;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_IMM;
        state_d   = is_sw_q ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        // Store retires in the cycle memory accepts it
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = ASB_B;
        aluop3     = ALU_SUB;
        pc_source  = PCS_ALUOUT;
        branch_eq  = br_q[0];
        branch_ne  = br_q[1];
        branch_gtz = br_q[2];
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`ifdef JUMP_EN
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCS_JUMP;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit. Stimulus is a queue of per-cycle
// records (reset, opcode, mem_ready, expected outputs) produced by a
// per-instruction model; one compare process checks every cycle.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       pc_write;
    logic       branch_eq;
    logic       branch_ne;
    logic       branch_gtz;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       instr_done;
  } outs_t;

  typedef struct {
    bit         rst;
    logic [5:0] op;
    logic       mr;
    outs_t      o;
  } rec_t;

  typedef struct {
    int id;
    int got;
    int want;
  } pin_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       pc_write, branch_eq, branch_ne, branch_gtz, iord, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, instr_done;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .branch_eq(branch_eq), .branch_ne(branch_ne),
    .branch_gtz(branch_gtz), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op),
    .instr_done(instr_done)
  );

  outs_t dut_o;
  assign dut_o = {pc_write, branch_eq, branch_ne, branch_gtz, iord, mem_read, mem_write,
                  ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                  alu_op, pc_source, illegal_op, instr_done};

  rec_t exp_q[$];
  pin_t pin_q[$];
  rec_t cur;
  bit   chk_en = 1'b0;
  int   total = 0, bad = 0, step = 0, done_seen = 0;

  // Single compare process: per-cycle outputs plus queued literal pins
  always @(negedge clk) begin
    while (pin_q.size() > 0) begin
      pin_t p;
      p = pin_q.pop_front();
      total++;
      if (p.got != p.want) begin
        bad++;
        $display("FAIL pin%0d: got %0d expected %0d", p.id, p.got, p.want);
      end
    end
    if (chk_en) begin
      total++;
      step++;
      if (dut_o !== cur.o) begin
        bad++;
        $display("FAIL step%0d op=%02h mr=%0b: got %h expected %h",
                 step, cur.op, cur.mr, dut_o, cur.o);
      end
      if (dut_o.instr_done === 1'b1) done_seen++;
    end
  end

  task automatic push(logic [5:0] op, logic mr, outs_t o);
    rec_t r;
    r.rst = 1'b1; r.op = op; r.mr = mr; r.o = o;
    exp_q.push_back(r);
  endtask

  task automatic push_rst(bit rst);
    rec_t r;
    r.rst = rst; r.op = 6'h00; r.mr = 1'b0; r.o = '0;
    exp_q.push_back(r);
  endtask

  task automatic pin(int id, int got, int want);
    pin_t p;
    p.id = id; p.got = got; p.want = want;
    pin_q.push_back(p);
  endtask

  function automatic outs_t o_fetch(logic mr);
    outs_t o;
    o = '0;
    o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr;
    return o;
  endfunction

  // Instruction model: fw / mw = cycles memory holds mem_ready low in the
  // fetch and data-access phases. mem_ready is toggled in other phases to
  // show it is ignored there.
  task automatic build(logic [5:0] op, int fw, int mw);
    outs_t o;
    for (int i = 0; i < fw; i++) push(op, 1'b0, o_fetch(1'b0));
    push(op, 1'b1, o_fetch(1'b1));
    o = '0; o.alu_src_b = 2'b11;
    case (op)
      6'b000000: begin
        push(op, 1'b0, o);
        o = '0; o.alu_src_a = 1'b1; o.alu_op = 3'b100; push(op, 1'b1, o);
        o = '0; o.reg_dst = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1; push(op, 1'b0, o);
      end
      6'b001000: begin
        push(op, 1'b1, o);
        o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 3'b010; push(op, 1'b0, o);
        o = '0; o.reg_write = 1'b1; o.instr_done = 1'b1; push(op, 1'b1, o);
      end
      6'b100011, 6'b101011: begin
        push(op, 1'b0, o);
        o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; push(op, 1'b1, o);
        o = '0; o.iord = 1'b1;
        if (op == 6'b100011) o.mem_read = 1'b1; else o.mem_write = 1'b1;
        for (int i = 0; i < mw; i++) push(op, 1'b0, o);
        if (op == 6'b101011) o.instr_done = 1'b1;
        push(op, 1'b1, o);
        if (op == 6'b100011) begin
          o = '0; o.mem_to_reg = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1;
          push(op, 1'b0, o);
        end
      end
      6'b000100, 6'b000101, 6'b000111: begin
        push(op, 1'b1, o);
        o = '0; o.alu_src_a = 1'b1; o.alu_op = 3'b001; o.pc_source = 2'b01; o.instr_done = 1'b1;
        o.branch_eq  = (op == 6'b000100);
        o.branch_ne  = (op == 6'b000101);
        o.branch_gtz = (op == 6'b000111);
        push(op, 1'b0, o);
      end
`ifdef JUMP_EN
      6'b000010: begin
        push(op, 1'b0, o);
        o = '0; o.pc_write = 1'b1; o.pc_source = 2'b10; o.instr_done = 1'b1; push(op, 1'b1, o);
      end
`endif
      default: begin
        o.illegal_op = 1'b1; push(op, 1'b1, o);
      end
    endcase
  endtask

  task automatic run();
    while (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      rst_n = cur.rst; opcode = cur.op; mem_ready = cur.mr;
      chk_en = 1'b1;
      @(posedge clk); #1;
    end
    chk_en = 1'b0;
  endtask

  initial begin
    int s0;
    outs_t bne_lit;
    int exp_done;
    @(posedge clk); #1;
    // reset held two cycles, then one IDLE cycle with all outputs low
    push_rst(1'b0); push_rst(1'b0); push_rst(1'b1);

    s0 = exp_q.size(); build(6'b000000, 0, 0); pin(1, exp_q.size() - s0, 4);
    s0 = exp_q.size(); build(6'b100011, 0, 3); pin(2, exp_q.size() - s0, 8);
    s0 = exp_q.size(); build(6'b000101, 0, 0); pin(3, exp_q.size() - s0, 3);
    bne_lit = '0;
    bne_lit.alu_src_a = 1'b1; bne_lit.alu_op = 3'b001; bne_lit.pc_source = 2'b01;
    bne_lit.branch_ne = 1'b1; bne_lit.instr_done = 1'b1;
    pin(4, int'(exp_q[exp_q.size()-1].o), int'(bne_lit));
    build(6'b000100, 2, 0);
    build(6'b000111, 0, 0);
    s0 = exp_q.size(); build(6'b111111, 0, 0); pin(5, exp_q.size() - s0, 2);
    s0 = exp_q.size(); build(6'b001000, 0, 0); pin(6, exp_q.size() - s0, 4);
    s0 = exp_q.size(); build(6'b101011, 0, 2); pin(7, exp_q.size() - s0, 6);
    build(6'b100011, 2, 1);
    s0 = exp_q.size(); build(6'b000010, 0, 0);
`ifdef JUMP_EN
    pin(8, exp_q.size() - s0, 3);
    exp_done = 11;
`else
    pin(8, exp_q.size() - s0, 2);
    exp_done = 10;
`endif
    build(6'b000001, 1, 0);
    // sw stalled in MEM_WRITE, then reset dropped mid-access
    s0 = exp_q.size(); build(6'b101011, 0, 5);
    while (exp_q.size() > s0 + 5) void'(exp_q.pop_back());
    push_rst(1'b0); push_rst(1'b0); push_rst(1'b1);
    build(6'b000000, 0, 0);
    build(6'b001000, 1, 0);

    run();
    pin(9, done_seen, exp_done);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
